// File: rtl/addr8s_frame_accum_pkg.sv
// Shared constants and state encoding for the frame accumulator.
// Optional saturation is selected with ADDR8S_FRAME_ACCUM_SAT_EN.
package addr8s_frame_accum_pkg;
  localparam int IN_W  = 9;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;
endpackage

// File: rtl/addr8s_acc_add.sv
// Signed ACC_W-bit adder with overflow flag; with ADDR8S_FRAME_ACCUM_SAT_EN
// defined the result clamps to the signed range, otherwise it wraps.
module addr8s_acc_add #(
  parameter int ACC_W = 12
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);
  logic [ACC_W-1:0] raw;

  assign raw = a + b;
  // Overflow only when both operands share a sign the result does not.
  assign ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);

`ifdef ADDR8S_FRAME_ACCUM_SAT_EN
  localparam logic [ACC_W-1:0] POS_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] NEG_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  assign sum = ovf ? (a[ACC_W-1] ? NEG_MIN : POS_MAX) : raw;
`else
  assign sum = raw;
`endif
endmodule

// File: rtl/addr8s_frame_accum.sv
// Frame accumulator: sums FRAME_LEN signed 9-bit samples (or fewer on flush)
// and holds the total until the consumer takes it. Macro: ADDR8S_FRAME_ACCUM_SAT_EN.
module addr8s_frame_accum
  import addr8s_frame_accum_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int ACC_W     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);
  localparam logic [CNT_W-1:0] LEN = CNT_W'(FRAME_LEN);

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             out_valid_q;

  logic [ACC_W-1:0] sum_ext;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic [CNT_W-1:0] cnt_inc;

  assign sum_ext = ACC_W'($signed(in_sum));
  assign cnt_inc = cnt_q + CNT_W'(1);

  addr8s_acc_add #(.ACC_W(ACC_W)) u_add (
    .a   (acc_q),
    .b   (sum_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_q <= sum_ext;
            cnt_q <= CNT_W'(1);
            ovf_q <= 1'b0;
            if (FRAME_LEN == 1 || flush) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_q <= add_sum;
            cnt_q <= cnt_inc;
            ovf_q <= ovf_q | add_ovf;
            if (cnt_inc == LEN || flush) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
            end
          end else if (flush) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          // No input is taken here, so the return to IDLE costs one bubble.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q != HOLD);
  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_cnt   = cnt_q;
  assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_addr8s_frame_accum.sv
// Bench for addr8s_frame_accum: four parameterisations share one stimulus
// stream; a frame-level model plus literal expectations check them.
module tb_addr8s_frame_accum;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b1;
  logic [8:0] in_sum = '0;

  logic [3:0]      ir, ov, oo;
  logic [3:0][7:0] oc;
  logic [11:0]     a4, a8, a1;
  logic [8:0]      a2;
  int              dacc [4];

  int  pass_cnt = 0;
  int  total_cnt = 0;
  bit  chk_en = 1'b0;

`ifdef ADDR8S_FRAME_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  // index 0: FL4/W12, 1: FL8/W12, 2: FL1/W12, 3: FL2/W9
  addr8s_frame_accum #(.FRAME_LEN(4), .ACC_W(12)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_sum(in_sum),
    .flush(flush), .out_valid(ov[0]), .out_ready(out_ready), .out_acc(a4),
    .out_cnt(oc[0]), .out_ovf(oo[0]));
  addr8s_frame_accum #(.FRAME_LEN(8), .ACC_W(12)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_sum(in_sum),
    .flush(flush), .out_valid(ov[1]), .out_ready(out_ready), .out_acc(a8),
    .out_cnt(oc[1]), .out_ovf(oo[1]));
  addr8s_frame_accum #(.FRAME_LEN(1), .ACC_W(12)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_sum(in_sum),
    .flush(flush), .out_valid(ov[2]), .out_ready(out_ready), .out_acc(a1),
    .out_cnt(oc[2]), .out_ovf(oo[2]));
  addr8s_frame_accum #(.FRAME_LEN(2), .ACC_W(9)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .in_sum(in_sum),
    .flush(flush), .out_valid(ov[3]), .out_ready(out_ready), .out_acc(a2),
    .out_cnt(oc[3]), .out_ovf(oo[3]));

  assign dacc[0] = int'($signed(a4));
  assign dacc[1] = int'($signed(a8));
  assign dacc[2] = int'($signed(a1));
  assign dacc[3] = int'($signed(a2));

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Frame-level model: each frame is a running integer total that is
  // clamped or wrapped into the signed range whenever it leaves it.
  int  FL [4] = '{4, 8, 1, 2};
  int  AW [4] = '{12, 12, 12, 9};
  bit  held [4];
  bit  infr [4];
  bit  movf [4];
  int  macc [4];
  int  mcnt [4];

  function automatic int madd(input int acc, input int s, input int w, inout bit o);
    int mx, mn, t;
    mx = (1 << (w - 1)) - 1;
    mn = -(1 << (w - 1));
    t  = acc + s;
    if (t > mx) begin
      o = 1'b1;
      t = SAT ? mx : t - (1 << w);
    end else if (t < mn) begin
      o = 1'b1;
      t = SAT ? mn : t + (1 << w);
    end
    return t;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        held[k] = 1'b0; infr[k] = 1'b0; movf[k] = 1'b0; macc[k] = 0; mcnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (held[k]) begin
          if (out_ready) held[k] = 1'b0;
        end else if (in_valid) begin
          if (!infr[k]) begin
            macc[k] = int'($signed(in_sum));
            mcnt[k] = 1;
            movf[k] = 1'b0;
            infr[k] = 1'b1;
          end else begin
            macc[k] = madd(macc[k], int'($signed(in_sum)), AW[k], movf[k]);
            mcnt[k] = mcnt[k] + 1;
          end
          if (mcnt[k] == FL[k] || flush) begin
            held[k] = 1'b1;
            infr[k] = 1'b0;
          end
        end else if (flush && infr[k]) begin
          held[k] = 1'b1;
          infr[k] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("u%0d_out_valid", k), int'(ov[k]), int'(held[k]));
        chk($sformatf("u%0d_in_ready", k), int'(ir[k]), int'(!held[k]));
        if (held[k]) begin
          chk($sformatf("u%0d_out_acc", k), dacc[k], macc[k]);
          chk($sformatf("u%0d_out_cnt", k), int'(oc[k]), mcnt[k]);
          chk($sformatf("u%0d_out_ovf", k), int'(oo[k]), int'(movf[k]));
        end
      end
    end
  end

  task automatic cyc(input bit v, input int s, input bit f, input bit r);
    in_valid  = v;
    in_sum    = 9'(s);
    flush     = f;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", int'(ov), 0);
    chk("rst_out_acc", dacc[0], 0);
    chk("rst_out_cnt", int'(oc[0]), 0);
    chk("rst_out_ovf", int'(oo), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    chk("first_in_ready", int'(ir), 15);

    // Four back-to-back samples into the length-4 frame.
    cyc(1, 5, 0, 1); cyc(1, -3, 0, 1); cyc(1, 100, 0, 1);
    chk("s1_valid_early", int'(ov[0]), 0);
    cyc(1, -256, 0, 1);
    chk("s1_valid", int'(ov[0]), 1);
    chk("s1_acc", dacc[0], -154);
    chk("s1_cnt", int'(oc[0]), 4);
    chk("s1_ovf", int'(oo[0]), 0);
    cyc(0, 0, 0, 1);
    chk("s1_taken", int'(ov[0]), 0);

    // 9-bit accumulator overflow.
    do_reset();
    cyc(1, 255, 0, 1); cyc(1, 255, 0, 1);
    chk("s2_valid", int'(ov[3]), 1);
    chk("s2_acc", dacc[3], SAT ? 255 : -2);
    chk("s2_ovf", int'(oo[3]), 1);
    cyc(0, 0, 0, 1);

    // Flush together with the 4th sample of a length-8 frame.
    do_reset();
    cyc(1, 10, 0, 1); cyc(1, 10, 0, 1); cyc(1, 10, 0, 1); cyc(1, 7, 1, 1);
    chk("s3_valid", int'(ov[1]), 1);
    chk("s3_acc", dacc[1], 37);
    chk("s3_cnt", int'(oc[1]), 4);
    cyc(0, 0, 0, 1);

    // Backpressure in HOLD, then bubble and a fresh frame.
    do_reset();
    cyc(1, 255, 0, 0); cyc(1, 255, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 9, 0, 0);
      chk("s4_hold_ready", int'(ir[3]), 0);
      chk("s4_hold_valid", int'(ov[3]), 1);
      chk("s4_hold_acc", dacc[3], SAT ? 255 : -2);
      chk("s4_hold_cnt", int'(oc[3]), 2);
    end
    cyc(1, 1, 0, 1);
    chk("s4_bubble_valid", int'(ov[3]), 0);
    chk("s4_bubble_ready", int'(ir[3]), 1);
    cyc(1, 1, 0, 1); cyc(1, 1, 0, 1);
    chk("s4_fresh_valid", int'(ov[3]), 1);
    chk("s4_fresh_acc", dacc[3], 2);
    chk("s4_fresh_ovf", int'(oo[3]), 0);
    cyc(0, 0, 0, 1);

    // Asynchronous reset mid-frame.
    do_reset();
    cyc(1, 50, 0, 1); cyc(1, 60, 0, 1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("s5_rst_valid", int'(ov), 0);
    chk("s5_rst_acc4", dacc[0], 0);
    chk("s5_rst_acc2", dacc[3], 0);
    chk("s5_rst_cnt", int'(oc[0]), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1, 1, 0, 1); cyc(1, 2, 0, 1); cyc(1, 3, 0, 1); cyc(1, 4, 0, 1);
    chk("s5_valid", int'(ov[0]), 1);
    chk("s5_acc", dacc[0], 10);
    chk("s5_cnt", int'(oc[0]), 4);
    cyc(0, 0, 0, 1);

    // Single-sample frames.
    do_reset();
    cyc(1, -256, 0, 1);
    chk("s6_valid", int'(ov[2]), 1);
    chk("s6_acc", dacc[2], -256);
    chk("s6_cnt", int'(oc[2]), 1);
    cyc(0, 0, 0, 1);

    // Flush without a sample, then flush in HOLD and IDLE is ignored.
    do_reset();
    cyc(1, 3, 0, 1); cyc(0, 0, 1, 1);
    chk("s7_valid", int'(ov[0]), 1);
    chk("s7_acc", dacc[0], 3);
    chk("s7_cnt", int'(oc[0]), 1);
    cyc(0, 0, 1, 1); cyc(0, 0, 1, 1);
    chk("s7_idle_flush", int'(ov[0]), 0);
    cyc(1, -7, 1, 1);
    chk("s7_idle_xfer_flush", int'(ov[1]), 1);
    chk("s7_idle_xfer_acc", dacc[1], -7);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/addr8s_frame_accum.md
ADDR8S_FRAME_ACCUM -- requirements
Module: addr8s_frame_accum

Interface
- REQ-001 SHALL have parameter FRAME_LEN, default 8, giving the number of sums per frame (legal range 1..255).
- REQ-002 SHALL have parameter ACC_W, default 12, giving the accumulator width in bits (legal range 9..32).
- REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-005 SHALL have port in_valid, input, 1 bit: in_sum is valid.
- REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts in_sum this cycle.
- REQ-007 SHALL have port in_sum, input, 9 bits: two's-complement O[8:0] from the upstream 8-bit signed adder.
- REQ-008 SHALL have port flush, input, 1 bit: ends the current frame early.
- REQ-009 SHALL have port out_valid, output, 1 bit: the frame result is valid.
- REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
- REQ-011 SHALL have port out_acc, output, ACC_W bits: the signed frame total.
- REQ-012 SHALL have port out_cnt, output, 8 bits: the number of sums in the frame.
- REQ-013 SHALL have port out_ovf, output, 1 bit: the accumulator overflowed at least once in the frame.

Function
- REQ-014 SHALL transfer an input when in_valid and in_ready are both 1 at the rising edge; the output transfers when out_valid and out_ready are both 1.
- REQ-015 SHALL use three states: IDLE, ACCUM, HOLD.
- REQ-016 SHALL drive in_ready = 1 in IDLE and ACCUM, and 0 in HOLD.
- REQ-017 SHALL drive out_valid = 1 only in HOLD; out_acc, out_cnt and out_ovf are registered and stay stable throughout HOLD.
- REQ-018 SHALL, on a transfer in IDLE, load acc = sign-extended in_sum, set cnt = 1, clear ovf, and go to ACCUM; if FRAME_LEN == 1, go to HOLD instead.
- REQ-019 SHALL, on a transfer in ACCUM, set acc = acc + sign-extended in_sum and cnt = cnt + 1; when the new cnt equals FRAME_LEN, go to HOLD.
- REQ-020 SHALL set ovf when the signed ACC_W-bit addition overflows; ovf stays set until the next frame starts.
- REQ-021 SHALL, on flush in ACCUM, go to HOLD with the current acc and cnt; if a transfer occurs in the same cycle, include that sample first.
- REQ-022 SHALL ignore flush in IDLE and in HOLD; flush together with a transfer in IDLE counts as a 1-sample frame and goes to HOLD.
- REQ-023 SHALL return to IDLE after an output transfer in HOLD; it accepts no input in that cycle, giving 1 bubble cycle.
- REQ-024 SHALL have a latency of 1 cycle from the edge capturing the last sample to out_valid = 1.

Reset
- REQ-025 SHALL, while rst = 1, force state = IDLE, acc = 0, cnt = 0, ovf = 0, out_valid = 0, out_acc = 0, out_cnt = 0, out_ovf = 0.
- REQ-026 SHALL discard any partial or held frame when reset is asserted mid-operation, and SHALL produce no output for it.
- REQ-027 SHALL have in_ready = 1 in the first cycle after rst deasserts.

Configuration
- REQ-028 SHALL, with macro ADDR8S_FRAME_ACCUM_SAT_EN defined, clamp acc on overflow to +2^(ACC_W-1)-1 or -2^(ACC_W-1), and set ovf.
- REQ-029 SHALL, without ADDR8S_FRAME_ACCUM_SAT_EN, wrap acc modulo 2^ACC_W and still set ovf.

Structure
- REQ-030 SHALL take the state enum (IDLE, ACCUM, HOLD) and the IN_W = 9 and CNT_W = 8 constants from package addr8s_frame_accum_pkg.
- REQ-031 SHALL place the signed add plus overflow/saturation logic in one sub-module, addr8s_acc_add, with inputs a[ACC_W], b[ACC_W] and outputs sum[ACC_W], ovf.

Verification
- REQ-032 SHALL cover: FRAME_LEN = 4, sums 5, -3, 100, -256 back-to-back, out_ready = 1 -> out_acc = -154, out_cnt = 4, out_ovf = 0, out_valid high 1 cycle after the 4th transfer.
- REQ-033 SHALL cover: ACC_W = 9, FRAME_LEN = 2, sums 255, 255 -> SAT_EN: out_acc = 255, out_ovf = 1; no SAT_EN: out_acc = -2, out_ovf = 1.
- REQ-034 SHALL cover: FRAME_LEN = 8, 3 sums of 10, then flush with a 4th sum of 7 in the same cycle -> out_acc = 37, out_cnt = 4.
- REQ-035 SHALL cover: result held with out_ready = 0 for 5 cycles while in_valid = 1 -> in_ready = 0, outputs stable; then out_ready = 1 -> 1 bubble cycle, next frame starts fresh with ovf = 0.
- REQ-036 SHALL cover: rst asserted asynchronously mid-frame after 2 sums -> all outputs 0 immediately; the next full frame totals correctly with no carry-over.
- REQ-037 SHALL cover: FRAME_LEN = 1, sum -256 -> out_acc = -256, out_cnt = 1, HOLD entered directly from IDLE.
